capture_buffer_mc: RTL and testbench
====================================

Name: capture_buffer_mc

Overview:
- Parametrised multi-channel capture buffer for the receive chain (DDC I/Q, magnitude and other taps).
- On arm, it discards a programmable number of valid input samples, optionally waits for a threshold trigger on one channel, then records a programmable number of samples from all channels into on-chip RAM.
- Recorded data is read back through a registered read port (host/debug interface).
- Replaces the fixed-length, fixed-delay capture with a run-time configurable, triggerable block.

Parameters:
- N_CH, 3, number of captured channels (1..8)
- WIDTH, 24, sample width per channel, bits
- DEPTH, 2048, samples per channel, power of two
- AW, log2(DEPTH), address width (derived, not overridden)
- SKIPW, 16, width of skip counter

Ports:
- clk_125  in  1  capture and read clock
- reset_b  in  1  asynchronous reset, active-low
- in_valid  in  1  sample strobe, one sample set per asserted cycle
- in_data  in  N_CH*WIDTH  channel k at bits [k*WIDTH +: WIDTH], two's complement
- arm  in  1  single-cycle start pulse
- abort  in  1  single-cycle stop pulse
- mode  in  1  0 = free capture after skip, 1 = threshold trigger
- skip_len  in  SKIPW  valid samples discarded after arm
- capture_len  in  AW+1  samples to record; 0 or > DEPTH means DEPTH
- trig_ch  in  3  trigger channel index
- threshold  in  WIDTH  unsigned magnitude threshold
- busy  out  1  high in SKIP, WAIT_TRIG and CAPTURE
- done  out  1  high in DONE
- wr_count  out  AW+1  samples written in current/last capture
- rd_en  in  1  read request
- rd_ch  in  3  read channel
- rd_addr  in  AW  read sample index
- rd_data  out  WIDTH  read data
- rd_valid  out  1  rd_data valid strobe

Behaviour:
- Reset: reset_b is asynchronous, active-low; clock is clk_125. Reset forces state IDLE and clears busy, done, wr_count, rd_data, rd_valid and all counters. RAM contents are not cleared.
- Config latch: mode, skip_len, capture_len (clamped), trig_ch and threshold are registered on the accepted arm cycle. Later input changes do not affect the run.
- States: IDLE, SKIP, WAIT_TRIG, CAPTURE, DONE.
- IDLE/DONE + arm -> SKIP:
  - skip counter = 0, wr_count = 0, done = 0.
  - busy rises the cycle after arm.
  - arm while busy is ignored.
- SKIP:
  - Each in_valid increments the skip counter; the sample is discarded.
  - When the counter equals latched skip_len: mode 0 -> CAPTURE, mode 1 -> WAIT_TRIG.
  - skip_len = 0: leave SKIP on the first cycle without consuming a sample.
- WAIT_TRIG:
  - Trigger when in_valid and |in_data[trig_ch]| >= threshold.
  - Absolute value: -2^(WIDTH-1) saturates to 2^(WIDTH-1)-1.
  - trig_ch >= N_CH never triggers.
  - The triggering sample is written at address 0 in the same cycle; state -> CAPTURE.
- CAPTURE:
  - Each in_valid writes all N_CH channels at address wr_count, then wr_count increments.
  - When wr_count reaches the latched length, go to DONE on the following cycle.
  - in_valid gaps stall capture without loss.
- DONE: done held high; wr_count holds.
- abort in SKIP, WAIT_TRIG or CAPTURE -> IDLE next cycle; busy and done go low and wr_count holds. abort wins over arm and over in_valid in the same cycle.
- Read port:
  - Fixed 2-cycle latency: rd_en at cycle t gives rd_valid and rd_data at t+2.
  - Back-to-back reads are supported, one per cycle.
  - Reads are allowed in any state. A read of an address written in the same cycle returns the old contents.
  - rd_ch >= N_CH returns 0 with rd_valid asserted.
  - rd_data holds its value when rd_valid is low.
- Storage: RAM is N_CH*WIDTH wide and DEPTH deep, inferable as block RAM with single write and single read.

Test Plan:
- Mode 0, skip_len=5, capture_len=8, in_valid every cycle, ramp data ch0=n, ch1=-n, ch2=2n:
  - done after 13 valid samples; wr_count=8.
  - Reads ch0 addr 0..7 return 5..12; ch1 addr 3 returns -8 (0xFFFFF8).
- Mode 1, skip_len=0, trig_ch=1, threshold=1000:
  - ch1 sequence 10, -999, -1000, 50: trigger on -1000.
  - addr 0 ch1 = -1000 (0xFFFC18); addr 1 ch1 = 50.
- in_valid every third cycle, capture_len=4: done follows the 4th valid sample; no duplicated or lost samples (addr k = k-th valid ramp value).
- capture_len=0 and capture_len=DEPTH+100: both record exactly DEPTH samples; wr_count=2048. Reads addr 0 and 2047 correct.
- abort mid-CAPTURE at wr_count=3:
  - Next cycle busy=0, done=0, wr_count=3.
  - Subsequent arm restarts from address 0.
  - arm pulsed while busy has no effect.
- Read port: rd_en on 3 consecutive cycles gives rd_valid on 3 consecutive cycles 2 cycles later. rd_ch=5 returns 0. Asserting reset_b=0 during CAPTURE clears busy, done and wr_count immediately.

Source files
------------

// File: rtl/capture_buffer_mc_if.sv
// capture_buffer_mc_if: sample, control, status and read-port bundle for capture_buffer_mc
// Ports (master = host/source side, slave = capture buffer side):
//   in_valid/in_data            sample strobe and packed channel data
//   arm/abort/mode/skip_len/capture_len/trig_ch/threshold  run control and config
//   busy/done/wr_count          run status
//   rd_en/rd_ch/rd_addr         read request, rd_data/rd_valid read response
interface capture_buffer_mc_if #(
    parameter int N_CH  = 3,
    parameter int WIDTH = 24,
    parameter int DEPTH = 2048,
    parameter int SKIPW = 16
);
    localparam int AW = $clog2(DEPTH);
    logic                  in_valid;
    logic [N_CH*WIDTH-1:0] in_data;
    logic                  arm;
    logic                  abort;
    logic                  mode;
    logic [SKIPW-1:0]      skip_len;
    logic [AW:0]           capture_len;
    logic [2:0]            trig_ch;
    logic [WIDTH-1:0]      threshold;
    logic                  busy;
    logic                  done;
    logic [AW:0]           wr_count;
    logic                  rd_en;
    logic [2:0]            rd_ch;
    logic [AW-1:0]         rd_addr;
    logic [WIDTH-1:0]      rd_data;
    logic                  rd_valid;
    modport master (
        output in_valid, in_data, arm, abort, mode, skip_len, capture_len, trig_ch, threshold,
        output rd_en, rd_ch, rd_addr,
        input  busy, done, wr_count, rd_data, rd_valid
    );
    modport slave (
        input  in_valid, in_data, arm, abort, mode, skip_len, capture_len, trig_ch, threshold,
        input  rd_en, rd_ch, rd_addr,
        output busy, done, wr_count, rd_data, rd_valid
    );
endinterface

// File: rtl/capture_buffer_mc.sv
// capture_buffer_mc: armable multi-channel capture buffer with skip, threshold trigger and registered read port
// Ports:
//   clk_125  capture and read clock
//   reset_b  asynchronous active-low reset
//   bus      capture_buffer_mc_if.slave: sample input, run control/config, status, read port
module capture_buffer_mc #(
    parameter int N_CH  = 3,
    parameter int WIDTH = 24,
    parameter int DEPTH = 2048,
    parameter int SKIPW = 16
) (
    input logic                 clk_125,
    input logic                 reset_b,
    capture_buffer_mc_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] full_len = (AW+1)'(DEPTH);
    localparam logic [WIDTH-1:0] most_neg = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, SKIP, WAIT_TRIG, CAPTURE, DONE} state_t;

    state_t                state, state_n;
    logic [SKIPW-1:0]      skip_cnt, skip_n, skip_q;
    logic [AW:0]           wr_count, wr_n, len_q, len_c;
    logic                  mode_q;
    logic [2:0]            trig_q;
    logic [WIDTH-1:0]      thr_q;
    logic                  load, we, busy, last, hit, trig_ok;
    logic [AW-1:0]         waddr;
    logic [WIDTH-1:0]      trig_s, mag;

    logic [N_CH*WIDTH-1:0] mem [DEPTH];
    logic [N_CH*WIDTH-1:0] rd_word;
    logic [2:0]            rd_ch_q;
    logic                  rd_v1;
    logic [WIDTH-1:0]      rd_sel, rd_data;
    logic                  rd_valid;

    assign busy         = state inside {SKIP, WAIT_TRIG, CAPTURE};
    assign bus.busy     = busy;
    assign bus.done     = state == DONE;
    assign bus.wr_count = wr_count;
    assign bus.rd_data  = rd_data;
    assign bus.rd_valid = rd_valid;

    // Zero or oversized lengths mean a full-depth capture.
    assign len_c = (bus.capture_len == '0 || bus.capture_len > full_len) ? full_len : bus.capture_len;
    assign last  = (wr_count + 1'b1) == len_q;

    // Trigger channel select; an out-of-range channel never qualifies.
    always_comb begin
        trig_s  = '0;
        trig_ok = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (trig_q == 3'(k)) begin
                trig_s  = bus.in_data[k*WIDTH +: WIDTH];
                trig_ok = 1'b1;
            end
        end
    end

    // Magnitude saturates at the most negative code so it stays in WIDTH bits.
    assign mag = !trig_s[WIDTH-1] ? trig_s : (trig_s == most_neg) ? ~most_neg : -trig_s;
    assign hit = trig_ok && mag >= thr_q;

    always_ff @(posedge clk_125 or negedge reset_b) begin
        if (!reset_b) begin
            state    <= IDLE;
            skip_cnt <= '0;
            wr_count <= '0;
            mode_q   <= 1'b0;
            skip_q   <= '0;
            len_q    <= '0;
            trig_q   <= '0;
            thr_q    <= '0;
        end else begin
            state    <= state_n;
            skip_cnt <= skip_n;
            wr_count <= wr_n;
            if (load) begin
                mode_q <= bus.mode;
                skip_q <= bus.skip_len;
                len_q  <= len_c;
                trig_q <= bus.trig_ch;
                thr_q  <= bus.threshold;
            end
        end
    end

    always_comb begin
        state_n = state;
        skip_n  = skip_cnt;
        wr_n    = wr_count;
        we      = 1'b0;
        waddr   = wr_count[AW-1:0];
        load    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bus.arm) begin
                    state_n = SKIP;
                    skip_n  = '0;
                    wr_n    = '0;
                    load    = 1'b1;
                end
            end
            SKIP: begin
                // The sample that brings the count to skip_len is still discarded.
                if (skip_q == '0) begin
                    state_n = mode_q ? WAIT_TRIG : CAPTURE;
                end else if (bus.in_valid) begin
                    skip_n = skip_cnt + 1'b1;
                    if (skip_n == skip_q) state_n = mode_q ? WAIT_TRIG : CAPTURE;
                end
            end
            WAIT_TRIG: begin
                if (bus.in_valid && hit) begin
                    we      = 1'b1;
                    waddr   = '0;
                    wr_n    = wr_count + 1'b1;
                    state_n = last ? DONE : CAPTURE;
                end
            end
            CAPTURE: begin
                if (bus.in_valid) begin
                    we   = 1'b1;
                    wr_n = wr_count + 1'b1;
                    if (last) state_n = DONE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (busy && bus.abort) begin
            state_n = IDLE;
            skip_n  = skip_cnt;
            wr_n    = wr_count;
            we      = 1'b0;
        end
    end

    // Single write, single registered read; read-before-write on address collision.
    always_ff @(posedge clk_125) begin
        if (we) mem[waddr] <= bus.in_data;
        if (bus.rd_en) rd_word <= mem[bus.rd_addr];
    end

    always_comb begin
        rd_sel = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (rd_ch_q == 3'(k)) rd_sel = rd_word[k*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk_125 or negedge reset_b) begin
        if (!reset_b) begin
            rd_v1    <= 1'b0;
            rd_ch_q  <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_v1    <= bus.rd_en;
            rd_valid <= rd_v1;
            if (bus.rd_en) rd_ch_q <= bus.rd_ch;
            if (rd_v1) rd_data <= rd_sel;
        end
    end
endmodule

// File: tb/tb_capture_buffer_mc.sv
// tb_capture_buffer_mc: directed self-checking bench for capture_buffer_mc
module tb_capture_buffer_mc;
    localparam int N_CH  = 3;
    localparam int WIDTH = 24;
    localparam int DEPTH = 2048;
    localparam int SKIPW = 16;
    localparam int AW    = $clog2(DEPTH);

    logic clk_125 = 1'b0;
    logic reset_b = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   n = 0;
    int   vc;

    capture_buffer_mc_if #(.N_CH(N_CH), .WIDTH(WIDTH), .DEPTH(DEPTH), .SKIPW(SKIPW)) bus ();

    capture_buffer_mc #(.N_CH(N_CH), .WIDTH(WIDTH), .DEPTH(DEPTH), .SKIPW(SKIPW)) dut (
        .clk_125 (clk_125),
        .reset_b (reset_b),
        .bus     (bus)
    );

    always #4 clk_125 = ~clk_125;

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_125);
        #1;
    endtask

    task automatic send(input int c0, input int c1, input int c2, input logic v);
        bus.in_data  = {24'(c2), 24'(c1), 24'(c0)};
        bus.in_valid = v;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic send_ramp(input logic v);
        send(n, -n, 2*n, v);
        if (v) n++;
    endtask

    task automatic start(input logic m, input int skip, input int len, input int tch, input int thr);
        bus.mode        = m;
        bus.skip_len    = SKIPW'(skip);
        bus.capture_len = (AW+1)'(len);
        bus.trig_ch     = 3'(tch);
        bus.threshold   = WIDTH'(thr);
        bus.arm         = 1'b1;
        tick();
        bus.arm         = 1'b0;
    endtask

    task automatic stop;
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
    endtask

    task automatic read_chk(input string tag, input int ch, input int addr, input int exp);
        bus.rd_en   = 1'b1;
        bus.rd_ch   = 3'(ch);
        bus.rd_addr = AW'(addr);
        tick();
        bus.rd_en   = 1'b0;
        tick();
        check(tag, {bus.rd_valid, bus.rd_data}, {1'b1, 24'(exp)});
    endtask

    task automatic run_until_done(input int budget, output int cnt);
        cnt = 0;
        while (!bus.done && cnt < budget) begin
            send_ramp(1'b1);
            cnt++;
        end
    endtask

    initial begin
        int exp_pipe [3];
        bus.in_valid = 0; bus.in_data = '0; bus.arm = 0; bus.abort = 0; bus.mode = 0;
        bus.skip_len = '0; bus.capture_len = '0; bus.trig_ch = '0; bus.threshold = '0;
        bus.rd_en = 0; bus.rd_ch = '0; bus.rd_addr = '0;
        repeat (3) tick();
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_wr", bus.wr_count, 0);
        check("rst_rd", {bus.rd_valid, bus.rd_data}, 0);
        reset_b = 1'b1;
        tick();

        // free capture: skip 5, record 8 of a ramp
        start(0, 5, 8, 0, 0);
        check("t1_busy", bus.busy, 1);
        run_until_done(100, vc);
        check("t1_count", vc, 13);
        check("t1_wr", bus.wr_count, 8);
        for (int k = 0; k < 8; k++) read_chk($sformatf("t1_ch0_a%0d", k), 0, k, 5 + k);
        read_chk("t1_ch1_a3", 1, 3, 'hFFFFF8);

        // threshold trigger on ch1 at -1000
        start(1, 0, 2, 1, 1000);
        send(0, 0, 0, 0);
        send(0, 10, 0, 1);
        send(0, -999, 0, 1);
        check("t2_notrig", bus.wr_count, 0);
        send(0, -1000, 0, 1);
        check("t2_trig", bus.wr_count, 1);
        send(0, 50, 0, 1);
        check("t2_done", {bus.done, bus.wr_count}, {1'b1, 12'd2});
        read_chk("t2_a0", 1, 0, 'hFFFC18);
        read_chk("t2_a1", 1, 1, 50);

        // most negative code saturates below a threshold of 2^23
        start(1, 0, 2, 1, 'h800000);
        send(0, 0, 0, 0);
        for (int k = 0; k < 3; k++) send(0, 'h800000, 0, 1);
        check("t2_sat", {bus.busy, bus.wr_count}, {1'b1, 12'd0});
        stop();
        check("t2_sat_abort", bus.busy, 0);

        // out-of-range trigger channel never fires
        start(1, 0, 2, 5, 0);
        send(0, 0, 0, 0);
        for (int k = 0; k < 3; k++) send(k, k, k, 1);
        check("t2_badch", {bus.busy, bus.wr_count}, {1'b1, 12'd0});
        stop();

        // sparse in_valid, capture_len 4
        n = 0;
        start(0, 0, 4, 0, 0);
        vc = 0;
        for (int i = 0; i < 60 && !bus.done; i++) begin
            send_ramp(i % 3 == 2);
            if (i % 3 == 2) vc++;
        end
        check("t3_count", vc, 4);
        for (int k = 0; k < 4; k++) read_chk($sformatf("t3_a%0d", k), 0, k, k);
        read_chk("t3_ch2_a3", 2, 3, 6);

        // capture_len 0 and oversized both record DEPTH samples
        n = 0;
        start(0, 0, 0, 0, 0);
        send_ramp(0);
        run_until_done(3000, vc);
        check("t4_len0_cnt", vc, DEPTH);
        check("t4_len0_wr", bus.wr_count, DEPTH);
        read_chk("t4_len0_a0", 0, 0, 0);
        read_chk("t4_len0_a2047", 2, DEPTH - 1, 2 * (DEPTH - 1));
        n = 100;
        start(0, 0, DEPTH + 100, 0, 0);
        send_ramp(0);
        run_until_done(3000, vc);
        check("t4_big_cnt", vc, DEPTH);
        check("t4_big_wr", bus.wr_count, DEPTH);
        read_chk("t4_big_a0", 0, 0, 100);
        read_chk("t4_big_a2047", 0, DEPTH - 1, 100 + DEPTH - 1);

        // abort at wr_count 3, arm while busy ignored, then restart
        n = 0;
        start(0, 0, 8, 0, 0);
        send_ramp(0);
        repeat (3) send_ramp(1);
        start(0, 0, 8, 0, 0);
        check("t5_rearm", {bus.busy, bus.wr_count}, {1'b1, 12'd3});
        bus.abort = 1'b1;
        send_ramp(1);
        bus.abort = 1'b0;
        check("t5_abort", {bus.busy, bus.done, bus.wr_count}, {2'b00, 12'd3});
        n = 100;
        start(0, 0, 8, 0, 0);
        send_ramp(0);
        repeat (2) send_ramp(1);
        check("t5_restart_wr", bus.wr_count, 2);
        stop();
        read_chk("t5_a0", 0, 0, 100);
        read_chk("t5_a1", 0, 1, 101);
        read_chk("t5_a2", 0, 2, 2);

        // back-to-back reads, hold when idle, bad channel
        exp_pipe = '{100, 101, 2};
        for (int i = 0; i < 5; i++) begin
            bus.rd_en   = (i < 3);
            bus.rd_ch   = 3'd0;
            bus.rd_addr = AW'(i);
            tick();
            if (i >= 1 && i <= 3)
                check($sformatf("t6_pipe%0d", i), {bus.rd_valid, bus.rd_data}, {1'b1, 24'(exp_pipe[i-1])});
            else
                check($sformatf("t6_idle%0d", i), {bus.rd_valid, bus.rd_data}, {1'b0, 24'd2});
        end
        bus.rd_en = 1'b0;
        read_chk("t6_ch5", 5, 0, 0);

        // asynchronous reset mid-capture
        start(0, 0, 8, 0, 0);
        send_ramp(0);
        repeat (2) send_ramp(1);
        check("t7_pre", {bus.busy, bus.wr_count}, {1'b1, 12'd2});
        @(negedge clk_125);
        reset_b = 1'b0;
        #1;
        check("t7_rst", {bus.busy, bus.done, bus.wr_count}, 0);
        tick();
        reset_b = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
